// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the N:1 arbitrated output-register mux.
//   clog2()     - ceiling log2, used to size channel indices (returns 0 for v <= 1).
//   MODE_FIXED  - rr_en value selecting the channel given by s.
//   MODE_RR     - rr_en value selecting rotating-priority round-robin.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_mux_nx1_if.sv
// arb_mux_nx1_if: channel-side and output-side handshake bundle of arb_mux_nx1.
//   rr_en    - mode (MODE_FIXED / MODE_RR)
//   s        - channel select in fixed mode
//   I        - packed channel data, channel k at [k*WIDTH +: WIDTH]
//   I_valid  - per-channel valid
//   I_ready  - per-channel accept strobe (one-hot or zero)
//   Y        - registered output word
//   Y_valid  - Y holds an unconsumed word
//   Y_ready  - downstream accepts Y this cycle
// Modports: slave = the mux, master = the environment driving it.
interface arb_mux_nx1_if
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
);
    localparam int unsigned SW = clog2(N);

    logic                 rr_en;
    logic [SW-1:0]        s;
    logic [N*WIDTH-1:0]   I;
    logic [N-1:0]         I_valid;
    logic [N-1:0]         I_ready;
    logic [WIDTH-1:0]     Y;
    logic                 Y_valid;
    logic                 Y_ready;

    modport slave (
        input  rr_en, s, I, I_valid, Y_ready,
        output I_ready, Y, Y_valid
    );

    modport master (
        output rr_en, s, I, I_valid, Y_ready,
        input  I_ready, Y, Y_valid
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: N-wide rotating-priority picker.
//   req      - request vector
//   ptr      - last served index; search order is ptr+1, ptr+2, ... wrapping, ending at ptr
//   gnt      - one-hot grant (zero when no request)
//   gnt_idx  - index of the granted request (0 when none)
//   any      - at least one request present
module rr_pick
    import mux_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    int unsigned   sum;
    logic [SW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sum     = 0;
        idx     = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            // ptr < N always, so a single subtract performs the wrap
            sum = 32'(ptr) + i;
            if (sum >= N) begin
                sum = sum - N;
            end
            idx = SW'(sum);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/arb_mux_nx1.sv
// arb_mux_nx1: N:1 arbitrated mux with a registered, back-pressured output word.
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - arb_mux_nx1_if.slave: channel inputs, per-channel I_ready, Y/Y_valid/Y_ready
// Fixed mode grants channel s; round-robin mode grants the next valid channel after ptr.
// ptr follows every transfer in either mode, so round-robin resumes after the last served.
module arb_mux_nx1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    arb_mux_nx1_if.slave     bus
);

    localparam int unsigned SW = clog2(N);
    localparam int unsigned NP = 1 << SW;

    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [SW-1:0]    ptr_q, ptr_d;

    // Padded to the full select range so s >= N reads a zero valid bit and never grants.
    logic [WIDTH-1:0] ch [NP];
    logic [NP-1:0]    valid_pad;

    for (genvar k = 0; k < NP; k++) begin : g_ch
        if (k < N) begin : g_real
            assign ch[k] = bus.I[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch[k] = '0;
        end
    end
    assign valid_pad = NP'(bus.I_valid);

    logic [N-1:0]  rr_gnt;
    logic [SW-1:0] rr_idx;
    logic          rr_any;

    rr_pick #(
        .N(N)
    ) u_pick (
        .req     (bus.I_valid),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    logic          load;
    logic          grant;
    logic          xfer;
    logic [SW-1:0] g_idx;
    logic [N-1:0]  gnt_vec;

    always_comb begin
        load = !y_valid_q || bus.Y_ready;
        if (bus.rr_en == MODE_RR) begin
            grant   = rr_any;
            g_idx   = rr_idx;
            gnt_vec = rr_gnt;
        end else begin
            grant   = valid_pad[bus.s];
            g_idx   = bus.s;
            gnt_vec = N'(valid_pad[bus.s]) << bus.s;
        end
        // rst_n gate keeps I_ready low in the reset cycle so no word is taken and lost
        xfer        = load && grant && rst_n;
        bus.I_ready = xfer ? gnt_vec : '0;

        y_d       = y_q;
        y_valid_d = y_valid_q;
        ptr_d     = ptr_q;
        if (xfer) begin
            y_d       = ch[g_idx];
            y_valid_d = 1'b1;
            ptr_d     = g_idx;
        end else if (bus.Y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            ptr_q     <= SW'(N - 1);
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.Y       = y_q;
    assign bus.Y_valid = y_valid_q;

endmodule

// File: tb/tb_arb_mux_nx1.sv
// tb_arb_mux_nx1: directed table-driven checks of arb_mux_nx1 (N=4) plus a
// hand-written sequence on an N=3 build for out-of-range fixed selects.
module tb_arb_mux_nx1;

    logic clk;
    logic rst_n;
    logic rst3_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    arb_mux_nx1_if #(.WIDTH(32), .N(4)) bus4 ();
    arb_mux_nx1_if #(.WIDTH(32), .N(3)) bus3 ();

    arb_mux_nx1 #(
        .WIDTH (32),
        .N     (4)
    ) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    arb_mux_nx1 #(
        .WIDTH (32),
        .N     (3)
    ) u_dut3 (
        .clk   (clk),
        .rst_n (rst3_n),
        .bus   (bus3)
    );

    typedef struct {
        logic         rst_n;
        logic         rr_en;
        logic [1:0]   s;
        logic [127:0] data;
        logic [3:0]   valid;
        logic         y_ready;
        logic [3:0]   exp_ready;
        logic         exp_yv;
        logic [31:0]  exp_y;
    } vec_t;

    localparam int NV = 24;
    localparam logic [127:0] D  = {32'd3, 32'd2, 32'd1, 32'd0};
    localparam logic [127:0] DB = {32'd3, 32'hDEAD_BEEF, 32'd1, 32'd0};

    vec_t vecs [NV];
    int   nchk;
    int   nerr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        nchk = 0;
        nerr = 0;

        // rst, rr, s, data, valid, y_ready, exp I_ready, exp Y_valid, exp Y
        vecs[0]  = '{1'b0, 1'b1, 2'd0, D,  4'b1111, 1'b1, 4'b0000, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 2'd2, DB, 4'b0100, 1'b1, 4'b0100, 1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 2'd1, D,  4'b0000, 1'b1, 4'b0000, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 1'b0, 2'd1, D,  4'b0010, 1'b0, 4'b0010, 1'b1, 32'd1};
        vecs[4]  = '{1'b1, 1'b1, 2'd0, D,  4'b1011, 1'b1, 4'b1000, 1'b1, 32'd3};
        vecs[5]  = '{1'b1, 1'b1, 2'd0, D,  4'b1011, 1'b1, 4'b0001, 1'b1, 32'd0};
        vecs[6]  = '{1'b1, 1'b1, 2'd0, D,  4'b1011, 1'b1, 4'b0010, 1'b1, 32'd1};
        vecs[7]  = '{1'b1, 1'b1, 2'd0, D,  4'b1111, 1'b0, 4'b0000, 1'b1, 32'd1};
        vecs[8]  = '{1'b1, 1'b0, 2'd3, D,  4'b1111, 1'b0, 4'b0000, 1'b1, 32'd1};
        vecs[9]  = '{1'b1, 1'b1, 2'd0, D,  4'b1111, 1'b0, 4'b0000, 1'b1, 32'd1};
        vecs[10] = '{1'b1, 1'b1, 2'd0, D,  4'b1111, 1'b1, 4'b0100, 1'b1, 32'd2};
        vecs[11] = '{1'b1, 1'b1, 2'd0, D,  4'b1111, 1'b1, 4'b1000, 1'b1, 32'd3};
        vecs[12] = '{1'b1, 1'b1, 2'd0, D,  4'b1111, 1'b1, 4'b0001, 1'b1, 32'd0};
        vecs[13] = '{1'b1, 1'b1, 2'd0, D,  4'b1111, 1'b1, 4'b0010, 1'b1, 32'd1};
        vecs[14] = '{1'b1, 1'b1, 2'd0, D,  4'b0010, 1'b1, 4'b0010, 1'b1, 32'd1};
        vecs[15] = '{1'b1, 1'b1, 2'd0, D,  4'b0010, 1'b1, 4'b0010, 1'b1, 32'd1};
        vecs[16] = '{1'b1, 1'b0, 2'd3, D,  4'b0111, 1'b1, 4'b0000, 1'b0, 32'd1};
        vecs[17] = '{1'b1, 1'b0, 2'd3, D,  4'b1000, 1'b0, 4'b1000, 1'b1, 32'd3};
        vecs[18] = '{1'b0, 1'b1, 2'd0, D,  4'b1111, 1'b1, 4'b0000, 1'b0, 32'd0};
        vecs[19] = '{1'b1, 1'b1, 2'd0, D,  4'b1111, 1'b1, 4'b0001, 1'b1, 32'd0};
        vecs[20] = '{1'b1, 1'b1, 2'd0, D,  4'b1111, 1'b1, 4'b0010, 1'b1, 32'd1};
        vecs[21] = '{1'b1, 1'b1, 2'd0, D,  4'b1111, 1'b1, 4'b0100, 1'b1, 32'd2};
        vecs[22] = '{1'b1, 1'b1, 2'd0, D,  4'b1111, 1'b1, 4'b1000, 1'b1, 32'd3};
        vecs[23] = '{1'b1, 1'b1, 2'd0, D,  4'b1111, 1'b1, 4'b0001, 1'b1, 32'd0};

        // N=3 build held in reset during the main table
        rst3_n        = 1'b0;
        bus3.rr_en    = 1'b0;
        bus3.s        = 2'd0;
        bus3.I        = {32'h32, 32'h31, 32'h30};
        bus3.I_valid  = 3'b000;
        bus3.Y_ready  = 1'b1;

        for (int i = 0; i < NV; i++) begin
            rst_n         = vecs[i].rst_n;
            bus4.rr_en    = vecs[i].rr_en;
            bus4.s        = vecs[i].s;
            bus4.I        = vecs[i].data;
            bus4.I_valid  = vecs[i].valid;
            bus4.Y_ready  = vecs[i].y_ready;
            @(negedge clk);
            check($sformatf("v%0d I_ready", i), 32'(bus4.I_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d Y_valid", i), 32'(bus4.Y_valid), 32'(vecs[i].exp_yv));
            check($sformatf("v%0d Y", i), bus4.Y, vecs[i].exp_y);
        end

        // N=3: one reset cycle, then s=3 must never grant over 5 cycles
        @(negedge clk);
        rst3_n = 1'b1;
        bus3.s       = 2'd3;
        bus3.I_valid = 3'b111;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("n3 s3 c%0d I_ready", c), 32'(bus3.I_ready), 32'd0);
            check($sformatf("n3 s3 c%0d Y_valid", c), 32'(bus3.Y_valid), 32'd0);
        end
        // legal select on the same build still works
        bus3.s = 2'd2;
        @(negedge clk);
        check("n3 s2 I_ready", 32'(bus3.I_ready), 32'b100);
        @(posedge clk);
        #1;
        check("n3 s2 Y_valid", 32'(bus3.Y_valid), 32'd1);
        check("n3 s2 Y", bus3.Y, 32'h32);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/arb_mux_nx1.md
ARB_MUX_NX1 -- requirements
Module: arb_mux_nx1

Interface
REQ-001 WIDTH, 32, data width in bits of every input channel and of the output.
REQ-002 N, 4, number of input channels; legal range 2..16.
REQ-003 SW, clog2(N), select width; derived, not overridden by instantiator.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 rr_en  input  1  0 = fixed-select mode (channel chosen by s); 1 = round-robin mode (s ignored).
REQ-007 s  input  SW  channel select in fixed-select mode.
REQ-008 I  input  N*WIDTH  channel data, packed; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 I_valid  input  N  per-channel data-valid.
REQ-010 I_ready  output  N  per-channel accept strobe; at most one bit high per cycle.
REQ-011 Y  output  WIDTH  registered output data.
REQ-012 Y_valid  output  1  Y holds a word not yet consumed.
REQ-013 Y_ready  input  1  downstream accepts Y this cycle.

Function
REQ-014 load = !Y_valid || Y_ready; output register accepts a new word only when load = 1.
REQ-015 Fixed mode: grant channel s when s < N and I_valid[s] = 1; otherwise no grant.
REQ-016 Fixed mode: s >= N never grants, never raises I_ready, never alters state.
REQ-017 Round-robin mode: grant first channel with I_valid = 1, searching ptr+1, ptr+2, ... wrapping modulo N, ending at ptr.
REQ-018 Round-robin mode: no valid channel -> no grant.
REQ-019 I_ready[g] = load && grant-exists && g == granted channel; all other bits 0; combinational, same cycle.
REQ-020 Transfer on channel g occurs in a cycle where I_valid[g] && I_ready[g]; next edge: Y <= channel g data, Y_valid <= 1.
REQ-021 Latency: input transfer to Y/Y_valid visible = 1 clock.
REQ-022 Y_valid && Y_ready with no grant -> Y_valid <= 0, Y holds last value.
REQ-023 Y_valid && Y_ready with grant -> consume and reload same edge, no bubble; full throughput 1 word/clk.
REQ-024 Y_valid && !Y_ready -> Y, Y_valid held; all I_ready = 0.
REQ-025 ptr (SW bits) updates to g on every transfer in either mode; unchanged otherwise.
REQ-026 Fixed-mode transfers also update ptr, so round-robin resumes after last served channel.
REQ-027 rr_en and s may change any cycle; take effect combinationally the same cycle; pending Y unaffected.
REQ-028 Single valid channel in round-robin mode is granted every load cycle (no forced skip).
REQ-029 Y never changes while Y_valid && !Y_ready.

Reset
REQ-030 rst_n = 0 at a rising edge: Y <= 0, Y_valid <= 0, ptr <= N-1 (first round-robin search starts at channel 0).
REQ-031 During reset cycle all I_ready = 0; pending output word discarded.
REQ-032 Reset asserted mid-transfer overrides the transfer; no data loaded.
REQ-033 First transfer possible in the first cycle after rst_n returns to 1.

Structure
REQ-034 Shared package mux_pkg holds clog2 function and mode constants MODE_FIXED = 0, MODE_RR = 1.
REQ-035 One sub-module rr_pick (N-wide rotating priority picker: inputs req, ptr; outputs gnt one-hot, gnt_idx, any) instantiated once.
REQ-036 Datapath mux and output register in arb_mux_nx1 itself; no latches; all registers reset.

Verification (WIDTH=32, N=4)
REQ-037 Reset: rst_n=0 one cycle with all I_valid=1 -> Y=0, Y_valid=0, I_ready=4'b0000.
REQ-038 Fixed: rr_en=0, s=2, I[2]=32'hDEAD_BEEF, I_valid=4'b0100, Y_ready=1 -> I_ready=4'b0100; next cycle Y=32'hDEAD_BEEF, Y_valid=1.
REQ-039 Fixed invalid select: N=3 build, s=3, all I_valid=1 -> I_ready=0, Y_valid stays 0 over 5 cycles.
REQ-040 Round-robin: rr_en=1, I_valid=4'b1111 held, Y_ready=1, channel k data = k -> Y sequence 0,1,2,3,0 on consecutive cycles.
REQ-041 Backpressure: Y_valid=1, Y=32'h11, Y_ready=0 for 3 cycles, I_valid=4'b1111 -> Y stays 32'h11, I_ready=0; Y_ready=1 -> next word loaded same edge, no bubble.
REQ-042 Mode switch: fixed transfer from channel 1, then rr_en=1 with I_valid=4'b1011 -> next grant channel 3, then 0.
